// File: rtl/spi_slave_param_if.sv
// SPI slave pad/host-side bus bundle for spi_slave_param.
// err_cnt exists only when SPI_SLAVE_ERR_CNT_EN is defined.
interface spi_slave_param_if #(
  parameter int unsigned DW = 8
);
  logic          SS_n;
  logic          MOSI;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          MISO;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;
  logic [2:0]    cs;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0]    err_cnt;

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output MISO, rx_data, rx_valid, frame_err, busy, cs, err_cnt
  );
  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  MISO, rx_data, rx_valid, frame_err, busy, cs, err_cnt
  );
`else
  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output MISO, rx_data, rx_valid, frame_err, busy, cs
  );
  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  MISO, rx_data, rx_valid, frame_err, busy, cs
  );
`endif
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: 2 command bits + DW payload bits, MSB first, read-back on MISO.
// Optional saturating abort counter on err_cnt when SPI_SLAVE_ERR_CNT_EN is defined.
module spi_slave_param #(
  parameter int unsigned DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_slave_param_if.slave   bus
);
  localparam int unsigned FW  = DW + 2;
  localparam int unsigned RCW = $clog2(FW);
  localparam int unsigned TCW = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t           r_cs, w_ns;
  logic [DW:0]      r_shift;
  logic [RCW-1:0]   r_bit_cnt;
  logic             r_rx_done;
  logic             r_rd_addr_seen;
  logic [DW-1:0]    r_tx_sh;
  logic [TCW-1:0]   r_tx_cnt;
  logic             r_tx_act;
  logic             r_tx_done;
  logic             r_miso;
  logic [FW-1:0]    r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_busy;

  logic w_rx_state, w_last_bit, w_complete, w_abort_err, w_tx_load;

  assign w_rx_state  = (r_cs == WRITE) || (r_cs == READ_ADD) || (r_cs == READ_DATA);
  assign w_last_bit  = w_rx_state && !r_rx_done && !bus.SS_n && (r_bit_cnt == RCW'(FW - 1));
  // A read-data frame is only complete once its last MISO bit has been driven.
  assign w_complete  = ((r_cs == WRITE) || (r_cs == READ_ADD)) ? r_rx_done :
                       (r_cs == READ_DATA)                     ? r_tx_done : 1'b0;
  assign w_abort_err = bus.SS_n && (r_cs != IDLE) && !w_complete;
  assign w_tx_load   = (r_cs == READ_DATA) && !bus.SS_n && r_rx_done && !r_tx_act &&
                       !r_tx_done && bus.tx_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cs <= IDLE;
    else        r_cs <= w_ns;
  end

  // Next-state decode; SS_n high always wins over MOSI
  always_comb begin
    w_ns = r_cs;
    case (r_cs)
      IDLE:      if (!bus.SS_n) w_ns = CHK_CMD;
      CHK_CMD: begin
        if (bus.SS_n)          w_ns = IDLE;
        else if (!bus.MOSI)    w_ns = WRITE;
        else if (r_rd_addr_seen) w_ns = READ_DATA;
        else                   w_ns = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (bus.SS_n) w_ns = IDLE;
      default:   w_ns = IDLE;
    endcase
  end

  // Receive shifter, transmit shifter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_rx_done      <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_sh        <= '0;
      r_tx_cnt       <= '0;
      r_tx_act       <= 1'b0;
      r_tx_done      <= 1'b0;
      r_miso         <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= w_abort_err;
      r_busy      <= (w_ns != IDLE);
      if (bus.SS_n || !w_rx_state) begin
        r_bit_cnt <= '0;
        r_rx_done <= 1'b0;
        r_tx_act  <= 1'b0;
        r_tx_done <= 1'b0;
        r_miso    <= 1'b0;
      end else begin
        if (w_last_bit) begin
          r_rx_data  <= {r_shift, bus.MOSI};
          r_rx_valid <= 1'b1;
          r_rx_done  <= 1'b1;
          if (r_cs == READ_ADD)  r_rd_addr_seen <= 1'b1;
          if (r_cs == READ_DATA) r_rd_addr_seen <= 1'b0;
        end else if (!r_rx_done) begin
          r_shift   <= {r_shift[DW-1:0], bus.MOSI};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_tx_load) begin
          r_miso   <= bus.tx_data[DW-1];
          r_tx_sh  <= {bus.tx_data[DW-2:0], 1'b0};
          r_tx_cnt <= TCW'(DW - 1);
          r_tx_act <= 1'b1;
        end else if (r_tx_act) begin
          if (r_tx_cnt == TCW'(0)) begin
            r_miso   <= 1'b0;
            r_tx_act <= 1'b0;
          end else begin
            r_miso   <= r_tx_sh[DW-1];
            r_tx_sh  <= {r_tx_sh[DW-2:0], 1'b0};
            r_tx_cnt <= r_tx_cnt - 1'b1;
            if (r_tx_cnt == TCW'(1)) r_tx_done <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of aborted frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_err_cnt <= 8'd0;
    else if (w_abort_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  assign bus.MISO      = r_miso;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;
  assign bus.cs        = r_cs;

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised frame-level bench for spi_slave_param (DW=8) against a transaction model.
module tb_spi_slave_param;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = DW + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  // Model state: last delivered frame, read-address flag, abort count
  logic [FW-1:0] m_rx_data;
  bit            m_rd_seen;
  int            m_err_cnt;

  spi_slave_param_if #(.DW(DW)) bus ();
  spi_slave_param #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [DW-1:0] rdw();
    return DW'($urandom);
  endfunction

  task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [DW-1:0] txd);
    bus.SS_n     = ss;
    bus.MOSI     = mosi;
    bus.tx_valid = txv;
    bus.tx_data  = txd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int e_cs, input bit e_rxv,
                            input bit e_err, input bit e_miso);
    check_eq({tag, ".cs"},        32'(bus.cs),        32'(e_cs));
    check_eq({tag, ".busy"},      32'(bus.busy),      32'(e_cs != 0));
    check_eq({tag, ".rx_valid"},  32'(bus.rx_valid),  32'(e_rxv));
    check_eq({tag, ".frame_err"}, 32'(bus.frame_err), 32'(e_err));
    check_eq({tag, ".MISO"},      32'(bus.MISO),      32'(e_miso));
    check_eq({tag, ".rx_data"},   32'(bus.rx_data),   32'(m_rx_data));
  endtask

  task automatic check_cnt(input string tag);
`ifdef SPI_SLAVE_ERR_CNT_EN
    check_eq({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_err_cnt));
`endif
  endtask

  task automatic do_abort(input string tag);
    tick(1'b1, rb(), rb(), rdw());
    if (m_err_cnt < 255) m_err_cnt++;
    check_outs(tag, 0, 1'b0, 1'b1, 1'b0);
    check_cnt(tag);
    tick(1'b1, rb(), rb(), rdw());
    check_outs({tag, "_post"}, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_rx_data = '0;
    m_rd_seen = 1'b0;
    m_err_cnt = 0;
    #1;
    check_outs(tag, 0, 1'b0, 1'b0, 1'b0);
    check_cnt(tag);
    bus.SS_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);
    check_outs({tag, "_idle"}, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // abort_at: 0 = SS_n high in CHK_CMD, k = high while bit k would be shifted,
  // FW+1 = high while READ_DATA waits for tx_valid; tx_cut j = stop after j MISO bits.
  task automatic run_frame(input logic d, input logic [FW-1:0] f, input int abort_at,
                           input int hold, input int tx_dly, input int tx_cut,
                           input bit cut_rst, input logic [DW-1:0] txd);
    int es;
    tick(1'b0, rb(), rb(), rdw());
    check_outs("chk", 1, 1'b0, 1'b0, 1'b0);
    if (abort_at == 0) begin do_abort("abort_chk"); return; end
    es = d ? (m_rd_seen ? 4 : 3) : 2;
    tick(1'b0, d, rb(), rdw());
    check_outs("enter", es, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(FW); i++) begin
      if (abort_at == i + 1) begin do_abort("abort_rx"); return; end
      tick(1'b0, f[FW-1-i], rb(), rdw());
      if (i == int'(FW) - 1) begin
        m_rx_data = f;
        if (es == 3) m_rd_seen = 1'b1;
        else if (es == 4) m_rd_seen = 1'b0;
        check_outs("rx_last", es, 1'b1, 1'b0, 1'b0);
      end else begin
        check_outs("rx_bit", es, 1'b0, 1'b0, 1'b0);
      end
    end
    if (es != 4) begin
      for (int h = 0; h < hold; h++) begin
        tick(1'b0, rb(), rb(), rdw());
        check_outs("hold", es, 1'b0, 1'b0, 1'b0);
      end
    end else begin
      for (int w = 0; w < tx_dly; w++) begin
        tick(1'b0, rb(), 1'b0, rdw());
        check_outs("tx_wait", 4, 1'b0, 1'b0, 1'b0);
      end
      if (abort_at == int'(FW) + 1) begin do_abort("abort_wait"); return; end
      tick(1'b0, rb(), 1'b1, txd);
      check_outs("tx_bit", 4, 1'b0, 1'b0, txd[DW-1]);
      for (int j = 1; j < int'(DW); j++) begin
        if (tx_cut == j) begin
          if (cut_rst) do_reset("rst_tx");
          else         do_abort("abort_tx");
          return;
        end
        tick(1'b0, rb(), rb(), rdw());
        check_outs("tx_bit", 4, 1'b0, 1'b0, txd[DW-1-j]);
      end
      for (int h = 0; h < hold + 1; h++) begin
        tick(1'b0, rb(), rb(), rdw());
        check_outs("tx_after", 4, 1'b0, 1'b0, 1'b0);
      end
    end
    tick(1'b1, rb(), rb(), rdw());
    check_outs("end", 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int r, ab, cut, gap;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    m_rx_data    = '0;
    m_rd_seen    = 1'b0;
    m_err_cnt    = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
    check_cnt("reset");
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);
    check_outs("idle", 0, 1'b0, 1'b0, 1'b0);

    // Directed: write, read pair (first goes to READ_ADD), abort, last-bit abort
    run_frame(1'b0, 10'h0A5, -1, 1, 0, 0, 1'b0, '0);
    run_frame(1'b1, 10'h230, -1, 0, 0, 0, 1'b0, '0);
    run_frame(1'b1, 10'h300, -1, 0, 0, 0, 1'b0, 8'hC3);
    run_frame(1'b0, 10'h1FF, 6, 0, 0, 0, 1'b0, '0);
    run_frame(1'b0, 10'h155, int'(FW), 0, 0, 0, 1'b0, '0);
    // Reset mid-transmit, then a read-data command must land in READ_ADD
    run_frame(1'b1, 10'h2AA, -1, 0, 0, 0, 1'b0, '0);
    run_frame(1'b1, 10'h3C0, -1, 0, 1, 4, 1'b1, 8'hA5);
    run_frame(1'b1, 10'h311, -1, 0, 0, 0, 1'b0, '0);

    for (int k = 0; k < 150; k++) begin
      r   = int'($urandom_range(0, 9));
      ab  = (r < 2) ? int'($urandom_range(0, FW + 1)) : -1;
      cut = (r == 2) ? int'($urandom_range(1, DW - 1)) : 0;
      run_frame(1'($urandom_range(0, 2) != 0), FW'($urandom), ab,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), cut,
                $urandom_range(0, 5) == 0, rdw());
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick(1'b1, rb(), rb(), rdw());
        check_outs("gap", 0, 1'b0, 1'b0, 1'b0);
      end
    end

`ifdef SPI_SLAVE_ERR_CNT_EN
    do_reset("cnt_rst");
    for (int k = 0; k < 3; k++) run_frame(rb(), FW'($urandom), 0, 0, 0, 0, 1'b0, '0);
    check_eq("err_cnt3", 32'(bus.err_cnt), 32'd3);
    for (int k = 0; k < 297; k++) run_frame(rb(), FW'($urandom), 0, 0, 0, 0, 1'b0, '0);
    check_eq("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
